// File: rtl/pipeline_mem_pkg.sv
// Shared types and constants for the MEM stage (pipeline_mem).
// Optional sub-word access support is enabled by defining MEMSTAGE_SUBWORD_EN.
package pipeline_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Access size codes carried on memsize_m when sub-word support is built in.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] BADDATA_DEFAULT = 32'hDEADBEEF;

  // True when the low address bits are illegal for the given access size.
  function automatic logic misaligned_addr(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/pipeline_memwb_reg.sv
// MEM/WB pipeline register: synchronous reset, bubble forces an all-zero entry.
module pipeline_memwb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        memtoreg_m,
  input  logic        link_m,
  input  logic        regwrite_m,
  input  logic [4:0]  writereg_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] readdata_m,
  input  logic [31:0] pcplus4_m,
  output logic        memtoreg_w,
  output logic        link_w,
  output logic        regwrite_w,
  output logic [4:0]  writereg_w,
  output logic [31:0] aluout_w,
  output logic [31:0] readdata_w,
  output logic [31:0] pcplus4_w
);

  // Load the stage every cycle; reset or a stall cycle loads a bubble.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      memtoreg_w <= 1'b0;
      link_w     <= 1'b0;
      regwrite_w <= 1'b0;
      writereg_w <= 5'd0;
      aluout_w   <= 32'd0;
      readdata_w <= 32'd0;
      pcplus4_w  <= 32'd0;
    end else begin
      memtoreg_w <= memtoreg_m;
      link_w     <= link_m;
      regwrite_w <= regwrite_m;
      writereg_w <= writereg_m;
      aluout_w   <= aluout_m;
      readdata_w <= readdata_m;
      pcplus4_w  <= pcplus4_m;
    end
  end

endmodule

// File: rtl/pipeline_mem.sv
// MEM stage: issues loads/stores on the data bus, stalls while an access is
// outstanding, and feeds the MEM/WB register.
// Optional macro MEMSTAGE_SUBWORD_EN adds byte/halfword accesses (big-endian lanes).
//
// Bus handshake: dmem_req is registered and held high for the whole access;
// the memory answers with a single-cycle dmem_ack, and dmem_rdata is valid in
// that same cycle. dmem_req drops on the edge that ends the access. dmem_ack
// while no request is pending is ignored.
module pipeline_mem
  import pipeline_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] BADDATA = BADDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_m,
  input  logic        memwrite_m,
  input  logic        memtoreg_m,
  input  logic        link_m,
  input  logic        regwrite_m,
  input  logic [4:0]  writereg_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  input  logic [31:0] pcplus4_m,
`ifdef MEMSTAGE_SUBWORD_EN
  input  logic [1:0]  memsize_m,
  input  logic        memsigned_m,
  output logic [3:0]  dmem_be,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        err,
  output logic        memtoreg_w,
  output logic        link_w,
  output logic        regwrite_w,
  output logic [4:0]  writereg_w,
  output logic [31:0] aluout_w,
  output logic [31:0] readdata_w,
  output logic [31:0] pcplus4_w,
  output logic        dbg_state
);

  mem_state_t  state;
  logic [7:0]  tcount;
  logic        memop;
  logic        misaligned;
  logic        timeout_hit;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [31:0] wb_readdata;

  assign memop       = memread_m | memwrite_m;
  assign timeout_hit = (state == ACCESS) && !dmem_ack && (tcount == 8'(TIMEOUT - 1));
  assign dbg_state   = (state == ACCESS);

`ifdef MEMSTAGE_SUBWORD_EN
  logic [3:0]  be_next;
  logic [31:0] lane_shift;

  // Alignment, lane enables, store replication and load extraction per size.
  always_comb begin
    misaligned = misaligned_addr(memsize_m, aluout_m[1:0]);
    lane_shift = dmem_rdata >> (5'd8 * (5'd3 - {3'd0, aluout_m[1:0]}));
    be_next    = 4'b1111;
    store_data = writedata_m;
    load_data  = dmem_rdata;
    case (memsize_m)
      SZ_BYTE: begin
        be_next    = 4'b1000 >> aluout_m[1:0];
        store_data = {4{writedata_m[7:0]}};
        load_data  = {{24{memsigned_m & lane_shift[7]}}, lane_shift[7:0]};
      end
      SZ_HALF: begin
        be_next    = aluout_m[1] ? 4'b0011 : 4'b1100;
        store_data = {2{writedata_m[15:0]}};
        load_data  = aluout_m[1]
                   ? {{16{memsigned_m & dmem_rdata[15]}}, dmem_rdata[15:0]}
                   : {{16{memsigned_m & dmem_rdata[31]}}, dmem_rdata[31:16]};
      end
      default: ;
    endcase
  end
`else
  // Word-only build: any nonzero low address bits are misaligned.
  always_comb begin
    misaligned = misaligned_addr(SZ_WORD, aluout_m[1:0]);
    store_data = writedata_m;
    load_data  = dmem_rdata;
  end
`endif

  // Stall and writeback read-data selection for the current cycle.
  always_comb begin
    mem_stall   = 1'b0;
    wb_readdata = 32'd0;
    case (state)
      IDLE: begin
        mem_stall = memop && !misaligned;
        if (memread_m && misaligned) wb_readdata = BADDATA;
      end
      ACCESS: begin
        mem_stall = !dmem_ack && !timeout_hit;
        if (dmem_ack) wb_readdata = memread_m ? load_data : 32'd0;
        else if (timeout_hit) wb_readdata = BADDATA;
      end
      default: ;
    endcase
  end

  // Access FSM with registered bus outputs, timeout counter and sticky err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tcount     <= 8'd0;
      err        <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
`ifdef MEMSTAGE_SUBWORD_EN
      dmem_be    <= 4'b0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          tcount <= 8'd0;
          if (memop && misaligned) begin
            err <= 1'b1;
          end else if (memop) begin
            state      <= ACCESS;
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite_m;
            dmem_addr  <= {aluout_m[31:2], 2'b00};
            dmem_wdata <= store_data;
`ifdef MEMSTAGE_SUBWORD_EN
            dmem_be    <= be_next;
`endif
          end
        end
        ACCESS: begin
          if (dmem_ack || timeout_hit) begin
            state    <= IDLE;
            tcount   <= 8'd0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!dmem_ack) err <= 1'b1;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pipeline_memwb_reg u_memwb (
    .clk        (clk),
    .reset      (reset),
    .bubble     (mem_stall),
    .memtoreg_m (memtoreg_m),
    .link_m     (link_m),
    .regwrite_m (regwrite_m),
    .writereg_m (writereg_m),
    .aluout_m   (aluout_m),
    .readdata_m (wb_readdata),
    .pcplus4_m  (pcplus4_m),
    .memtoreg_w (memtoreg_w),
    .link_w     (link_w),
    .regwrite_w (regwrite_w),
    .writereg_w (writereg_w),
    .aluout_w   (aluout_w),
    .readdata_w (readdata_w),
    .pcplus4_w  (pcplus4_w)
  );

endmodule

// File: tb/tb_pipeline_mem.sv
// Testbench for pipeline_mem (TIMEOUT overridden to 4).
// Build with MEMSTAGE_SUBWORD_EN to also exercise the sub-word load path.
module tb_pipeline_mem;

  localparam int          TO  = 4;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_m, memwrite_m, memtoreg_m, link_m, regwrite_m;
  logic [4:0]  writereg_m;
  logic [31:0] aluout_m, writedata_m, pcplus4_m;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, err;
  logic        memtoreg_w, link_w, regwrite_w;
  logic [4:0]  writereg_w;
  logic [31:0] aluout_w, readdata_w, pcplus4_w;
  logic        dbg_state;
`ifdef MEMSTAGE_SUBWORD_EN
  logic [1:0]  memsize_m;
  logic        memsigned_m;
  logic [3:0]  dmem_be;
  logic [3:0]  seen_be;
`endif

  int errors = 0;
  int checks = 0;
  logic err_model = 1'b0;

  typedef struct {
    logic        rd, wr, regwrite, memtoreg, link;
    logic [4:0]  wreg;
    logic [31:0] alu, wdata, pc4, rdata;
    int          delay;      // ACCESS cycles before ack; >= TO means never
    logic        noise;      // ack asserted while no request is pending
    int          exp_stalls;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  // clock / reset block
  always #5 clk = ~clk;

  pipeline_mem #(.TIMEOUT(TO), .BADDATA(BAD)) dut (
    .clk(clk), .reset(reset),
    .memread_m(memread_m), .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m),
    .link_m(link_m), .regwrite_m(regwrite_m), .writereg_m(writereg_m),
    .aluout_m(aluout_m), .writedata_m(writedata_m), .pcplus4_m(pcplus4_m),
`ifdef MEMSTAGE_SUBWORD_EN
    .memsize_m(memsize_m), .memsigned_m(memsigned_m), .dmem_be(dmem_be),
`endif
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .err(err),
    .memtoreg_w(memtoreg_w), .link_w(link_w), .regwrite_w(regwrite_w),
    .writereg_w(writereg_w), .aluout_w(aluout_w), .readdata_w(readdata_w),
    .pcplus4_w(pcplus4_w), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one instruction from the architectural rules.
  function automatic logic is_mis(input vec_t v);
    return (v.rd | v.wr) && (v.alu[1:0] != 2'b00);
  endfunction

  function automatic int model_req_cycles(input vec_t v);
    if (!(v.rd | v.wr) || is_mis(v)) return 0;
    return (v.delay < TO) ? v.delay + 1 : TO;
  endfunction

  function automatic vec_t model_fill(input vec_t v);
    vec_t r = v;
    r.exp_stalls = model_req_cycles(v);
    if (r.exp_stalls == TO && v.delay >= TO) r.exp_stalls = TO;
    r.exp_rdata = 32'd0;
    if (v.rd | v.wr) begin
      if (is_mis(v)) r.exp_rdata = v.rd ? BAD : 32'd0;
      else if (v.delay >= TO) r.exp_rdata = BAD;
      else r.exp_rdata = v.rd ? v.rdata : 32'd0;
      if (is_mis(v) || v.delay >= TO) err_model = 1'b1;
    end
    r.exp_err = err_model;
    return r;
  endfunction

  task automatic idle_inputs();
    memread_m = 0; memwrite_m = 0; memtoreg_m = 0; link_m = 0; regwrite_m = 0;
    writereg_m = 0; aluout_m = 0; writedata_m = 0; pcplus4_m = 0;
    dmem_ack = 0; dmem_rdata = 0;
`ifdef MEMSTAGE_SUBWORD_EN
    memsize_m = 2'b10; memsigned_m = 0;
`endif
  endtask

  // driver + memory responder for one instruction; called at posedge+1
  task automatic run_instr(input string tag, input vec_t v);
    int stalls = 0;
    int acc = 0;
    int cyc = 0;
    logic done = 0;
    memread_m = v.rd; memwrite_m = v.wr; regwrite_m = v.regwrite;
    memtoreg_m = v.memtoreg; link_m = v.link; writereg_m = v.wreg;
    aluout_m = v.alu; writedata_m = v.wdata; pcplus4_m = v.pc4;
    while (!done && cyc < 64) begin
      dmem_ack   = dmem_req ? (acc == v.delay) : v.noise;
      dmem_rdata = dmem_req ? v.rdata : $urandom;
      #1;
      if (dmem_req && acc == 0) begin
        chk({tag, " addr"}, dmem_addr, {v.alu[31:2], 2'b00});
        chk({tag, " we"}, dmem_we, v.wr);
        if (v.wr) chk({tag, " wdata"}, dmem_wdata, v.wdata);
`ifdef MEMSTAGE_SUBWORD_EN
        seen_be = dmem_be;
`endif
      end
      if (mem_stall) stalls++;
      else done = 1;
      if (dmem_req) acc++;
      @(posedge clk); #1;
      cyc++;
      if (!done)
        chk({tag, " bubble"}, {regwrite_w, memtoreg_w, link_w, writereg_w, aluout_w, readdata_w, pcplus4_w}, 0);
    end
    dmem_ack = 0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s cycle bound: stall still %0d after %0d cycles", tag, mem_stall, cyc);
    end
    chk({tag, " stalls"}, stalls, v.exp_stalls);
    chk({tag, " req_cycles"}, acc, model_req_cycles(v));
    chk({tag, " wb"}, {regwrite_w, memtoreg_w, link_w, writereg_w, aluout_w, pcplus4_w},
        {v.regwrite, v.memtoreg, v.link, v.wreg, v.alu, v.pc4});
    chk({tag, " readdata"}, readdata_w, v.exp_rdata);
    chk({tag, " err"}, err, v.exp_err);
    chk({tag, " req_dropped"}, dmem_req, 1'b0);
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    reset = 1;
    // {rd,wr,rw,m2r,link,wreg,alu,wdata,pc4,rdata,delay,noise,stalls,exp_rdata,exp_err}
    tbl[0] = '{0,0,1,0,0,5'd5, 32'h10, 32'h0, 32'h44, 32'h0, 0,0, 0, 32'h0, 0};
    tbl[1] = '{1,0,1,1,0,5'd8, 32'h100, 32'h0, 32'h48, 32'hCAFEF00D, 3,0, 4, 32'hCAFEF00D, 0};
    tbl[2] = '{0,1,0,0,0,5'd0, 32'h103, 32'h55AA55AA, 32'h4C, 32'h0, 0,0, 0, 32'h0, 1};
    tbl[3] = '{1,0,1,1,0,5'd9, 32'h104, 32'h0, 32'h50, 32'h12345678, 0,0, 1, 32'h12345678, 1};
    tbl[4] = '{1,0,1,1,0,5'd10, 32'h200, 32'h0, 32'h54, 32'h87654321, 9,0, 4, 32'hDEADBEEF, 1};
    tbl[5] = '{0,0,1,0,1,5'd31, 32'h0, 32'h0, 32'h58, 32'h0, 0,1, 0, 32'h0, 1};

    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("reset req", dmem_req, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset state", dbg_state, 1'b0);
    chk("reset stall", mem_stall, 1'b0);
    chk("reset wb", {regwrite_w, memtoreg_w, link_w, writereg_w, aluout_w, readdata_w, pcplus4_w}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_instr($sformatf("vec%0d", i), tbl[i]);
    err_model = 1'b1;

    // randomized instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 2);
      v.rd = (kind == 1); v.wr = (kind == 2);
      v.regwrite = $urandom; v.memtoreg = $urandom; v.link = $urandom;
      v.wreg = 5'($urandom); v.alu = $urandom; v.wdata = $urandom;
      v.pc4 = $urandom; v.rdata = $urandom;
      if ($urandom_range(0, 2) != 0) v.alu[1:0] = 2'b00;
      v.delay = $urandom_range(0, TO + 1);
      v.noise = $urandom;
      v = model_fill(v);
      run_instr($sformatf("rnd%0d", i), v);
    end

    // reset during the second ACCESS cycle discards the access
    memread_m = 1; memwrite_m = 0; regwrite_m = 1; writereg_m = 5'd3;
    aluout_m = 32'h300; pcplus4_m = 32'h60; dmem_ack = 0;
    @(posedge clk); #1;
    chk("rst_mid req1", dmem_req, 1'b1);
    @(posedge clk); #1;
    chk("rst_mid req2", dmem_req, 1'b1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    #1;
    chk("rst_mid req", dmem_req, 1'b0);
    chk("rst_mid state", dbg_state, 1'b0);
    chk("rst_mid err", err, 1'b0);
    chk("rst_mid wb", {regwrite_w, memtoreg_w, link_w, writereg_w, aluout_w, readdata_w, pcplus4_w}, 0);
    dmem_ack = 1; dmem_rdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    dmem_ack = 0;
    #1;
    chk("late_ack req", dmem_req, 1'b0);
    chk("late_ack state", dbg_state, 1'b0);
    chk("late_ack readdata", readdata_w, 32'h0);
    err_model = 1'b0;
    @(posedge clk); #1;

`ifdef MEMSTAGE_SUBWORD_EN
    // signed byte load from lane 1
    memsize_m = 2'b00; memsigned_m = 1;
    v = '{1,0,1,1,0,5'd4, 32'h201, 32'h0, 32'h64, 32'h1180FF22, 0,0, 1, 32'hFFFFFF80, 0};
    run_instr("lb_signed", v);
    chk("lb_signed be", seen_be, 4'b0100);
    idle_inputs();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
